// File: rtl/mii_frame_receive.sv
// MII receive path: strips preamble/SFD, assembles bytes, filters on destination MAC and checks length/FCS.
// Bytes leave through a 5-byte delay line so the trailing FCS is never emitted.
module mii_frame_receive #(
   parameter bit MAC_FILTER_EN   = 1'b1,
   parameter int PREAMBLE_MIN    = 8,
   parameter int MIN_FRAME_BYTES = 64,
   parameter int MAX_FRAME_BYTES = 1518
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [47:0] local_mac,
   input  logic        rx_en,
   input  logic        rx_dv,
   input  logic        rx_er,
   input  logic [3:0]  rx_d,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        frame_done,
   output logic        frame_good,
   output logic        err_crc,
   output logic        err_len,
   output logic        err_phy,
   output logic [15:0] frames_ok,
   output logic [15:0] frames_bad
);

   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [10:0] MIN_B       = 11'(MIN_FRAME_BYTES);
   localparam logic [10:0] MAX_B       = 11'(MAX_FRAME_BYTES);
   localparam logic [7:0]  PRE_MIN     = 8'(PREAMBLE_MIN);

   typedef enum logic [2:0] {
      S_SKIP,
      S_IDLE,
      S_PREAMBLE,
      S_DATA,
      S_DROP_SILENT
   } state_t;

   state_t      r_state;
   logic [7:0]  r_pre_cnt;
   logic [10:0] r_byte_cnt;
   logic [31:0] r_crc;
   logic [3:0]  r_lo;
   logic        r_half;
   logic [7:0]  r_dly [5];

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   logic [7:0]  w_byte;
   logic        w_byte_done;
   logic [10:0] w_cnt_next;
   logic [31:0] w_crc_next;
   logic [47:0] w_dest;
   logic        w_mac_ok;
   logic        w_err_len;
   logic        w_err_crc;
   logic        w_err_phy;
   logic        w_good;

   assign w_byte      = {rx_d, r_lo};
   assign w_byte_done = rx_en && (r_state == S_DATA) && rx_dv && !rx_er && r_half;
   assign w_cnt_next  = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
   assign w_crc_next  = crc32_byte(r_crc, w_byte);
   assign w_dest      = {r_dly[4], r_dly[3], r_dly[2], r_dly[1], r_dly[0], w_byte};
   assign w_mac_ok    = !MAC_FILTER_EN || (w_dest == local_mac) || (w_dest == 48'hFFFF_FFFF_FFFF);

   // Verdict for a frame ending on this strobe; CRC only judged when the frame holds whole bytes.
   assign w_err_len = (r_byte_cnt < MIN_B) || (r_byte_cnt > MAX_B);
   assign w_err_crc = !r_half && (r_crc != CRC_RESIDUE);
   assign w_err_phy = r_half;
   assign w_good    = !(w_err_len || w_err_crc || w_err_phy);

   // NOTE: the delay line has no reset; its contents are only read once 5 bytes of a frame have filled it.
   always_ff @(posedge clk) begin
      if (w_byte_done) begin
         r_dly[0] <= w_byte;
         for (int i = 1; i < 5; i++) r_dly[i] <= r_dly[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_SKIP;
         r_pre_cnt  <= '0;
         r_byte_cnt <= '0;
         r_crc      <= '1;
         r_lo       <= '0;
         r_half     <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
         frame_good <= 1'b0;
         err_crc    <= 1'b0;
         err_len    <= 1'b0;
         err_phy    <= 1'b0;
         frames_ok  <= '0;
         frames_bad <= '0;
      end else begin
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
         frame_good <= 1'b0;
         err_crc    <= 1'b0;
         err_len    <= 1'b0;
         err_phy    <= 1'b0;
         if (rx_en) begin
            unique case (r_state)
               S_SKIP: if (!rx_dv) r_state <= S_IDLE;
               S_IDLE: begin
                  if (rx_dv && rx_d == 4'h5) begin
                     r_state   <= S_PREAMBLE;
                     r_pre_cnt <= 8'd1;
                  end
               end
               S_PREAMBLE: begin
                  if (!rx_dv) begin
                     r_state <= S_IDLE;
                  end else if (rx_d == 4'h5) begin
                     if (r_pre_cnt != 8'hFF) r_pre_cnt <= r_pre_cnt + 8'd1;
                  end else if (rx_d == 4'hD && r_pre_cnt >= PRE_MIN) begin
                     r_state    <= S_DATA;
                     r_crc      <= '1;
                     r_byte_cnt <= '0;
                     r_half     <= 1'b0;
                  end else begin
                     r_state <= S_SKIP;
                  end
               end
               S_DATA: begin
                  if (!rx_dv) begin
                     r_state    <= S_IDLE;
                     frame_done <= 1'b1;
                     frame_good <= w_good;
                     err_len    <= w_err_len;
                     err_crc    <= w_err_crc;
                     err_phy    <= w_err_phy;
                     if (w_good) frames_ok  <= frames_ok + 16'd1;
                     else        frames_bad <= frames_bad + 16'd1;
                     if (r_byte_cnt >= 11'd6) begin
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        out_data  <= r_dly[4];
                     end
                  end else if (rx_er) begin
                     r_state    <= S_SKIP;
                     frame_done <= 1'b1;
                     err_phy    <= 1'b1;
                     frames_bad <= frames_bad + 16'd1;
                  end else if (!r_half) begin
                     r_lo   <= rx_d;
                     r_half <= 1'b1;
                  end else begin
                     r_half     <= 1'b0;
                     r_crc      <= w_crc_next;
                     r_byte_cnt <= w_cnt_next;
                     if (w_cnt_next > MAX_B) begin
                        r_state    <= S_SKIP;
                        frame_done <= 1'b1;
                        err_len    <= 1'b1;
                        frames_bad <= frames_bad + 16'd1;
                     end else if (r_byte_cnt == 11'd5 && !w_mac_ok) begin
                        r_state <= S_DROP_SILENT;
                     end else if (r_byte_cnt >= 11'd5) begin
                        out_valid <= 1'b1;
                        out_data  <= r_dly[4];
                     end
                  end
               end
               S_DROP_SILENT: if (!rx_dv) r_state <= S_IDLE;
               default: r_state <= S_SKIP;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mii_frame_receive.sv
// Scoreboard bench for mii_frame_receive: expected bytes and verdicts are queued as frames are driven
// and compared as the receiver produces them.
module tb_mii_frame_receive;

   localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
   localparam int          MIN_B     = 64;
   localparam int          MAX_B     = 1518;
   localparam int          PRE_MIN   = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [47:0] local_mac = LOCAL_MAC;
   logic        rx_en = 1'b0;
   logic        rx_dv = 1'b0;
   logic        rx_er = 1'b0;
   logic [3:0]  rx_d = 4'h0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        frame_done;
   logic        frame_good;
   logic        err_crc;
   logic        err_len;
   logic        err_phy;
   logic [15:0] frames_ok;
   logic [15:0] frames_bad;

   mii_frame_receive #(
      .MAC_FILTER_EN  (1'b1),
      .PREAMBLE_MIN   (PRE_MIN),
      .MIN_FRAME_BYTES(MIN_B),
      .MAX_FRAME_BYTES(MAX_B)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .local_mac (local_mac),
      .rx_en     (rx_en),
      .rx_dv     (rx_dv),
      .rx_er     (rx_er),
      .rx_d      (rx_d),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .frame_done(frame_done),
      .frame_good(frame_good),
      .err_crc   (err_crc),
      .err_len   (err_len),
      .err_phy   (err_phy),
      .frames_ok (frames_ok),
      .frames_bad(frames_bad)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         gap = 0;
   bit         lenient = 1'b0;
   int         exp_ok = 0;
   int         exp_bad = 0;
   logic [8:0] exp_q[$];   // {last, data}
   logic [3:0] vq[$];      // {good, crc, len, phy}
   logic [7:0] fb[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'h0, d};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   // Monitor: outputs sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      logic [8:0] e;
      logic [3:0] v;
      if (!reset) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("byte_extra_allowed", 32'(lenient), 32'd1);
               check("byte_extra_last", 32'(out_last), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(e[7:0]));
               check("out_last", 32'(out_last), 32'(e[8]));
            end
         end
         if (frame_done) begin
            check("done_expected", 32'(vq.size() != 0), 32'd1);
            if (vq.size() != 0) begin
               v = vq.pop_front();
               check("verdict_gcLp", 32'({frame_good, err_crc, err_len, err_phy}), 32'(v));
            end
         end
      end
   end

   task automatic nib(input logic dv, input logic er, input logic [3:0] d);
      repeat (gap) begin
         rx_en = 1'b0;
         @(posedge clk); #1;
      end
      rx_en = 1'b1; rx_dv = dv; rx_er = er; rx_d = d;
      @(posedge clk); #1;
      rx_en = 1'b0; rx_er = 1'b0;
   endtask

   task automatic build(input logic [47:0] dest, input int n, input bit corrupt);
      logic [31:0] c;
      fb.delete();
      for (int j = 0; j < n - 4; j++) begin
         if (j < 6)       fb.push_back(dest[47-8*j -: 8]);
         else if (j < 12) fb.push_back(8'hA0 + 8'(j));
         else             fb.push_back(8'($urandom));
      end
      c = 32'hFFFF_FFFF;
      foreach (fb[j]) c = crc_byte(c, fb[j]);
      c = ~c;
      for (int k = 0; k < 4; k++) fb.push_back(c[8*k +: 8]);
      if (corrupt) fb[n-1] = fb[n-1] ^ 8'h04;
   endtask

   task automatic send_frame(input int pre_nibs, input bit corrupt, input bit odd,
                             input int er_byte, input int rst_byte);
      int         n;
      int         emit_to;
      bit         last;
      bit         has_v;
      bit         mac_ok;
      bit         c_bad, l_bad;
      logic [3:0] v;
      logic [7:0] b;
      logic [47:0] dest;
      n = fb.size();
      emit_to = -1; last = 1'b0; has_v = 1'b0; v = 4'h0;
      dest = 48'h0;
      for (int j = 0; j < 6 && j < n; j++) dest[47-8*j -: 8] = fb[j];
      mac_ok = (n < 6) || (dest == LOCAL_MAC) || (dest == 48'hFFFF_FFFF_FFFF);
      if (pre_nibs < PRE_MIN) begin
         emit_to = -1;
      end else if (rst_byte >= 0) begin
         emit_to = rst_byte - 6;
      end else if (!mac_ok) begin
         emit_to = -1;
      end else if (er_byte >= 0) begin
         emit_to = er_byte - 6; has_v = 1'b1; v = 4'b0001;
      end else if (n > MAX_B) begin
         emit_to = MAX_B - 6; has_v = 1'b1; v = 4'b0010;
      end else begin
         if (n >= 6) begin emit_to = n - 5; last = 1'b1; end
         c_bad = !odd && corrupt;
         l_bad = (n < MIN_B);
         has_v = 1'b1;
         v = {!(c_bad || l_bad || odd), c_bad, l_bad, odd};
      end
      for (int i = 0; i <= emit_to; i++) exp_q.push_back({last && (i == emit_to), fb[i]});
      if (has_v) begin
         vq.push_back(v);
         if (v[3]) exp_ok++; else exp_bad++;
      end

      repeat (pre_nibs) nib(1'b1, 1'b0, 4'h5);
      nib(1'b1, 1'b0, 4'hD);
      for (int i = 0; i < n; i++) begin
         b = fb[i];
         if (i == rst_byte) begin
            @(negedge clk); #1;
            reset = 1'b1;
            exp_ok = 0; exp_bad = 0;
            @(negedge clk);
            check("rst_frames_ok", 32'(frames_ok), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
         end
         if (rst_byte >= 0 && i == rst_byte + 2) reset = 1'b0;
         if (i == er_byte) begin
            nib(1'b1, 1'b1, b[3:0]);
            @(negedge clk);
            check("done_latency_phy", 32'(frame_done), 32'd1);
            repeat (4) nib(1'b1, 1'b0, 4'h5);
            break;
         end
         nib(1'b1, 1'b0, b[3:0]);
         nib(1'b1, 1'b0, b[7:4]);
         if (n > MAX_B && i == MAX_B) begin
            @(negedge clk);
            check("done_latency_len", 32'(frame_done), 32'd1);
         end
      end
      if (odd) nib(1'b1, 1'b0, 4'h3);
      nib(1'b0, 1'b0, 4'h0);
      if (has_v && er_byte < 0 && n <= MAX_B) begin
         @(negedge clk);
         check("done_latency", 32'(frame_done), 32'd1);
      end
      repeat (12) nib(1'b0, 1'b0, 4'h0);
      check("bytes_drained", 32'(exp_q.size()), 32'd0);
      check("verdicts_drained", 32'(vq.size()), 32'd0);
      check("frames_ok", 32'(frames_ok), 32'(exp_ok));
      check("frames_bad", 32'(frames_bad), 32'(exp_bad));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_counters", 32'({frames_ok, frames_bad}), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) nib(1'b0, 1'b0, 4'h0);

      // Good frame, then the same frame with a flipped FCS bit.
      build(LOCAL_MAC, 64, 1'b0);                send_frame(15, 1'b0, 1'b0, -1, -1);
      build(LOCAL_MAC, 64, 1'b1);                send_frame(15, 1'b1, 1'b0, -1, -1);
      // Foreign destination dropped silently; broadcast accepted.
      build(48'h02_00_00_00_00_02, 64, 1'b0);    send_frame(15, 1'b0, 1'b0, -1, -1);
      build(48'hFF_FF_FF_FF_FF_FF, 64, 1'b0);    send_frame(15, 1'b0, 1'b0, -1, -1);
      // PHY error abort, recovery, oversize abort, largest legal frame.
      build(LOCAL_MAC, 64, 1'b0);                send_frame(15, 1'b0, 1'b0, 20, -1);
      build(LOCAL_MAC, 64, 1'b0);                send_frame(15, 1'b0, 1'b0, -1, -1);
      lenient = 1'b1;
      build(LOCAL_MAC, 1600, 1'b0);              send_frame(15, 1'b0, 1'b0, -1, -1);
      lenient = 1'b0;
      build(LOCAL_MAC, MAX_B, 1'b0);             send_frame(15, 1'b0, 1'b0, -1, -1);
      // Short preamble ignored; undersize frames; odd nibble count.
      build(LOCAL_MAC, 64, 1'b0);                send_frame(5, 1'b0, 1'b0, -1, -1);
      build(LOCAL_MAC, 40, 1'b0);                send_frame(15, 1'b0, 1'b0, -1, -1);
      build(LOCAL_MAC, 4, 1'b0);                 send_frame(15, 1'b0, 1'b0, -1, -1);
      build(LOCAL_MAC, 64, 1'b0);                send_frame(15, 1'b0, 1'b1, -1, -1);
      // Reset mid-frame, then recovery; finally strobe every 4th clock.
      build(LOCAL_MAC, 64, 1'b0);                send_frame(15, 1'b0, 1'b0, -1, 30);
      build(LOCAL_MAC, 64, 1'b0);                send_frame(15, 1'b0, 1'b0, -1, -1);
      gap = 3;
      build(LOCAL_MAC, 64, 1'b0);                send_frame(15, 1'b0, 1'b0, -1, -1);
      gap = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
